backprop_update_engine: RTL and testbench

- Sequential backward-pass and weight-update unit for one learning neuron.
- Owns the neuron's weight store (N_INPUTS dendrite weights plus one bias) and drives it to the forward neuron.
- On a start handshake it takes the error and training ratio, walks one weight per cycle, and produces a per-input backprop change. It updates the weights in place, then pulses done.
- It is the backward and write end of the path whose forward end reads these weights.

---
 rtl/neuron_pkg.sv | 22 ++
 rtl/lr_scaler.sv | 25 ++
 rtl/backprop_update_engine.sv | 153 +++++++++++++++
 tb/tb_backprop_update_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, default sizes and the guarded divide used by the neuron's
// backward-pass / weight-update datapath.
package neuron_pkg;

  localparam int WIDTH    = 32;
  localparam int N_INPUTS = 32;

  typedef logic signed [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {IDLE, SCALE, WALK, DONE} bpe_state_t;

  // A zero denominator behaves as 1; signed '/' truncates toward zero.
  function automatic logic signed [2*WIDTH-1:0] safe_div(
    input logic signed [2*WIDTH-1:0] num,
    input word_t                     den
  );
    logic signed [2*WIDTH-1:0] den_ext;
    den_ext = (den == '0) ? (2*WIDTH)'(1) : {{WIDTH{den[WIDTH-1]}}, den};
    return num / den_ext;
  endfunction

endpackage

// File: rtl/lr_scaler.sv
// Combinational learning-rate scaling: delta = (backprop * mul) / div, with the
// product kept at full double width before the divide.
module lr_scaler
  import neuron_pkg::*;
(
  input  word_t backprop,
  input  word_t mul,
  input  word_t div,
  output word_t delta
);

  logic signed [2*WIDTH-1:0] bp_ext;
  logic signed [2*WIDTH-1:0] mul_ext;
  logic signed [2*WIDTH-1:0] product;
  logic signed [2*WIDTH-1:0] quotient;

  always_comb begin
    bp_ext   = {{WIDTH{backprop[WIDTH-1]}}, backprop};
    mul_ext  = {{WIDTH{mul[WIDTH-1]}}, mul};
    product  = bp_ext * mul_ext;
    quotient = safe_div(product, div);
    delta    = WIDTH'(quotient);
  end

endmodule

// File: rtl/backprop_update_engine.sv
// Backward pass and in-place weight update for one neuron: owns the weight
// store, walks one weight per cycle, and pulses done when the pass completes.
module backprop_update_engine #(
  parameter  int N_INPUTS = neuron_pkg::N_INPUTS,
  parameter  int WIDTH    = neuron_pkg::WIDTH,
  localparam int IDX_W    = $clog2(N_INPUTS + 1)
) (
  input  logic                            bpe_clock,
  input  logic                            bpe_reset,
  input  logic                            bpe_start,
  output logic                            bpe_ready,
  input  logic [N_INPUTS*WIDTH-1:0]       bpe_dendrites,
  input  logic [WIDTH-1:0]                bpe_backprop,
  input  logic [WIDTH-1:0]                bpe_trainingMul,
  input  logic [WIDTH-1:0]                bpe_trainingDiv,
  input  logic                            bpe_load,
  input  logic [IDX_W-1:0]                bpe_load_idx,
  input  logic [WIDTH-1:0]                bpe_load_data,
  output logic [(N_INPUTS+1)*WIDTH-1:0]   bpe_weights,
  output logic [N_INPUTS*WIDTH-1:0]       bpe_backpropChange,
  output logic                            bpe_busy,
  output logic                            bpe_done
);

  import neuron_pkg::*;

  bpe_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [WIDTH-1:0] weights_q [N_INPUTS+1];
  logic signed [WIDTH-1:0] weights_d [N_INPUTS+1];
  logic signed [WIDTH-1:0] change_q  [N_INPUTS];
  logic signed [WIDTH-1:0] change_d  [N_INPUTS];
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] dend_q [N_INPUTS];
  logic signed [WIDTH-1:0] backprop_q, mul_q, div_q, delta_q;
  logic signed [WIDTH-1:0] scaled_delta;
  logic signed [WIDTH-1:0] w_sel, d_sel;
  logic                    accept;

  lr_scaler u_lr_scaler (
    .backprop (backprop_q),
    .mul      (mul_q),
    .div      (div_q),
    .delta    (scaled_delta)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    weights_d = weights_q;
    change_d  = change_q;
    accept    = 1'b0;
    w_sel     = '0;
    d_sel     = '0;

    for (int i = 0; i < N_INPUTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_sel = weights_q[i];
        d_sel = dend_q[i];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bpe_start) begin
          accept  = 1'b1;
          state_d = SCALE;
        end else if (bpe_load) begin
          for (int i = 0; i <= N_INPUTS; i++) begin
            if (bpe_load_idx == IDX_W'(i)) weights_d[i] = bpe_load_data;
          end
        end
      end
      SCALE: begin
        idx_d   = '0;
        state_d = WALK;
      end
      WALK: begin
        if (idx_q == IDX_W'(N_INPUTS)) begin
          weights_d[N_INPUTS] = weights_q[N_INPUTS] + delta_q;
          state_d             = DONE;
        end else begin
          // The change uses the weight as it was before this edge's update.
          for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              change_d[i]  = backprop_q * w_sel;
              weights_d[i] = w_sel + delta_q * d_sel;
            end
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SCALE) || (state_d == WALK);
    done_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge bpe_clock or posedge bpe_reset) begin
    if (bpe_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      weights_q <= '{default: '0};
      change_q  <= '{default: '0};
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      weights_q <= weights_d;
      change_q  <= change_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: operand latches carry no reset; they are always rewritten at accept
  // before use, unlike the weight store, which must clear to zero on reset.
  always_ff @(posedge bpe_clock) begin
    if (accept) begin
      for (int i = 0; i < N_INPUTS; i++) dend_q[i] <= bpe_dendrites[i*WIDTH +: WIDTH];
      backprop_q <= bpe_backprop;
      mul_q      <= bpe_trainingMul;
      div_q      <= bpe_trainingDiv;
    end
    if (state_q == SCALE) delta_q <= scaled_delta;
  end

  for (genvar g = 0; g <= N_INPUTS; g++) begin : g_weights_out
    assign bpe_weights[g*WIDTH +: WIDTH] = weights_q[g];
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_change_out
    assign bpe_backpropChange[g*WIDTH +: WIDTH] = change_q[g];
  end

  assign bpe_ready = ready_q;
  assign bpe_busy  = busy_q;
  assign bpe_done  = done_q;

endmodule

// File: tb/tb_backprop_update_engine.sv
// Directed and randomized passes through backprop_update_engine, checked
// against an arithmetic reference model of the weight store.
module tb_backprop_update_engine;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int IW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bpe_start;
  logic                 bpe_ready;
  logic [N*W-1:0]       bpe_dendrites;
  logic [W-1:0]         bpe_backprop;
  logic [W-1:0]         bpe_trainingMul;
  logic [W-1:0]         bpe_trainingDiv;
  logic                 bpe_load;
  logic [IW-1:0]        bpe_load_idx;
  logic [W-1:0]         bpe_load_data;
  logic [(N+1)*W-1:0]   bpe_weights;
  logic [N*W-1:0]       bpe_backpropChange;
  logic                 bpe_busy;
  logic                 bpe_done;

  backprop_update_engine dut (
    .bpe_clock          (clk),
    .bpe_reset          (rst),
    .bpe_start          (bpe_start),
    .bpe_ready          (bpe_ready),
    .bpe_dendrites      (bpe_dendrites),
    .bpe_backprop       (bpe_backprop),
    .bpe_trainingMul    (bpe_trainingMul),
    .bpe_trainingDiv    (bpe_trainingDiv),
    .bpe_load           (bpe_load),
    .bpe_load_idx       (bpe_load_idx),
    .bpe_load_data      (bpe_load_data),
    .bpe_weights        (bpe_weights),
    .bpe_backpropChange (bpe_backpropChange),
    .bpe_busy           (bpe_busy),
    .bpe_done           (bpe_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] m_w    [N+1];
  logic signed [31:0] m_chg  [N];
  logic signed [31:0] m_dend [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_w(input int i);
    return bpe_weights[i*W +: W];
  endfunction

  function automatic logic [31:0] dut_chg(input int i);
    return bpe_backpropChange[i*W +: W];
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i <= N; i++) check($sformatf("%s_w%0d", tag, i), dut_w(i), m_w[i]);
    for (int i = 0; i < N; i++) check($sformatf("%s_chg%0d", tag, i), dut_chg(i), m_chg[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i <= N; i++) m_w[i] = '0;
    for (int i = 0; i < N; i++) m_chg[i] = '0;
  endtask

  // Reference pass: scale in 64-bit arithmetic, then apply every update at once.
  task automatic model_pass(input logic signed [31:0] bp, input logic signed [31:0] mul,
                            input logic signed [31:0] div);
    longint             prod, den;
    logic signed [31:0] delta;
    prod  = longint'(bp) * longint'(mul);
    den   = (div == 0) ? 64'sd1 : longint'(div);
    delta = 32'(prod / den);
    for (int i = 0; i < N; i++) begin
      m_chg[i] = 32'(longint'(bp) * longint'(m_w[i]));
      m_w[i]   = m_w[i] + 32'(longint'(delta) * longint'(m_dend[i]));
    end
    m_w[N] = m_w[N] + delta;
  endtask

  task automatic randomize_dend();
    for (int i = 0; i < N; i++) m_dend[i] = $urandom;
  endtask

  task automatic load_w(input int idx, input logic [31:0] data);
    bpe_load      = 1'b1;
    bpe_load_idx  = IW'(idx);
    bpe_load_data = data;
    @(posedge clk); #1;
    bpe_load = 1'b0;
    if (idx <= N) m_w[idx] = data;
  endtask

  task automatic check_reset_state(input string tag);
    model_clear();
    check({tag, "_ready"}, {31'd0, bpe_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, bpe_busy},  32'd0);
    check({tag, "_done"},  {31'd0, bpe_done},  32'd0);
    compare_all(tag);
  endtask

  // Asserts reset between clock edges and checks the state before any edge.
  task automatic reset_between_edges(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_state(tag);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic start_pass(input logic [31:0] bp, input logic [31:0] mul,
                            input logic [31:0] div, input bit load_too);
    for (int i = 0; i < N; i++) bpe_dendrites[i*W +: W] = m_dend[i];
    bpe_backprop    = bp;
    bpe_trainingMul = mul;
    bpe_trainingDiv = div;
    bpe_start       = 1'b1;
    if (load_too) begin
      bpe_load      = 1'b1;
      bpe_load_idx  = IW'($urandom_range(0, N));
      bpe_load_data = $urandom | 32'h1;
    end
    @(posedge clk); #1;
    bpe_start = 1'b0;
    bpe_load  = 1'b0;
  endtask

  task automatic run_pass(input string tag, input logic [31:0] bp, input logic [31:0] mul,
                          input logic [31:0] div, input int inject_at, input bit load_too);
    int first;
    int ndone;
    start_pass(bp, mul, div, load_too);
    check({tag, "_busy_at_accept"},  {31'd0, bpe_busy},  32'd1);
    check({tag, "_ready_at_accept"}, {31'd0, bpe_ready}, 32'd0);
    model_pass(bp, mul, div);
    first = 0;
    ndone = 0;
    for (int e = 1; e <= 60; e++) begin
      if (e == inject_at) begin
        bpe_start     = 1'b1;
        bpe_load      = 1'b1;
        bpe_load_idx  = IW'(3);
        bpe_load_data = $urandom | 32'h1;
      end
      @(posedge clk); #1;
      bpe_start = 1'b0;
      bpe_load  = 1'b0;
      if (bpe_done) begin
        ndone++;
        if (first == 0) first = e;
      end
      if (first != 0 && e == first + 1)
        check({tag, "_ready_after_done"}, {31'd0, bpe_ready}, 32'd1);
      if (first != 0 && e == first + 3) break;
    end
    check({tag, "_done_latency"}, 32'(first), 32'(N + 2));
    check({tag, "_done_count"},   32'(ndone), 32'd1);
    check({tag, "_busy_end"},     {31'd0, bpe_busy}, 32'd0);
    compare_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst             = 1'b1;
    bpe_start       = 1'b0;
    bpe_load        = 1'b0;
    bpe_load_idx    = '0;
    bpe_load_data   = '0;
    bpe_dendrites   = '0;
    bpe_backprop    = '0;
    bpe_trainingMul = '0;
    bpe_trainingDiv = '0;
    for (int i = 0; i < N; i++) m_dend[i] = '0;

    #12 check_reset_state("por");
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Directed pass with hand-computed results.
    load_w(0, 32'sd3);
    load_w(1, -32'sd2);
    load_w(N + 5, 32'h5555_5555);
    m_dend[0] = 32'sd10;
    m_dend[1] = 32'sd1;
    run_pass("basic", 32'sd5, 32'sd2, 32'sd4, 0, 1'b0);
    check("basic_chg0_const", dut_chg(0), 32'sd15);
    check("basic_chg1_const", dut_chg(1), -32'sd10);
    check("basic_w0_const",   dut_w(0),   32'sd23);
    check("basic_w1_const",   dut_w(1),   32'sd0);
    check("basic_bias_const", dut_w(N),   32'sd2);

    // Negative quotient truncation, then divide by zero.
    reset_between_edges("midreset");
    randomize_dend();
    run_pass("negdiv", -32'sd5, 32'sd1, 32'sd2, 0, 1'b0);
    check("negdiv_bias_const", dut_w(N), -32'sd2);
    randomize_dend();
    run_pass("zerodiv", -32'sd3, 32'sd1, 32'sd0, 0, 1'b0);
    check("zerodiv_bias_const", dut_w(N), -32'sd5);

    // Weight update wraps with no saturation.
    load_w(0, 32'h7FFF_FFFF);
    for (int i = 0; i < N; i++) m_dend[i] = '0;
    m_dend[0] = 32'sd1;
    run_pass("wrap", 32'sd1, 32'sd1, 32'sd1, 0, 1'b0);
    check("wrap_w0_const", dut_w(0), 32'h8000_0000);

    // start/load during WALK are ignored; start wins over a same-cycle load.
    randomize_dend();
    run_pass("walk_inject", $urandom, $urandom, $urandom_range(1, 1000), 6, 1'b0);
    randomize_dend();
    run_pass("start_and_load", $urandom, $urandom, $urandom_range(1, 1000), 0, 1'b1);

    // Reset while the walk is at index 10, then a clean pass.
    randomize_dend();
    start_pass($urandom, $urandom, 32'sd7, 1'b0);
    repeat (11) @(posedge clk);
    reset_between_edges("walkreset");
    for (int i = 0; i < 8; i++) load_w($urandom_range(0, N), $urandom);
    randomize_dend();
    run_pass("after_reset", $urandom, $urandom, -32'sd9, 0, 1'b0);

    // Randomized passes over random weight stores.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) load_w($urandom_range(0, N), $urandom);
      randomize_dend();
      run_pass($sformatf("rand%0d", p), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'sd0 : 32'($urandom), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
